// File: rtl/tmds_channel_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//
// Decodes one TMDS channel on the receive side of an HDMI/DVI link. It takes
// the 10-bit word from the deserializer (bit 0 first on the wire) and recovers
// the 8-bit pixel byte, the data-enable flag and the 2-bit control code.
//
// The word boundary is found by a small state machine. It pulses bitslip to
// the deserializer until it sees a run of control tokens. After that it holds
// lock for as long as tokens keep arriving.
//
// Decoding runs whether or not the channel is aligned. Downstream logic
// qualifies the video outputs with aligned.
//
// Ports
//   aclk           in   1   pixel-rate clock
//   aresetn        in   1   synchronous active-low reset
//   s_tmds_data    in  10   deserialized TMDS word
//   s_tmds_valid   in   1   qualifies s_tmds_data
//   bitslip        out  1   one-cycle request to shift the word boundary
//   aligned        out  1   high while the word boundary is locked
//   m_video_data   out  8   decoded pixel byte (0 for control tokens)
//   m_video_de     out  1   1 = data word, 0 = control token
//   m_video_ctrl   out  2   last control code seen (held during data words)
//   m_video_valid  out  1   s_tmds_valid delayed by the 2-cycle pipeline
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
   parameter int TOKEN_COUNT    = 8,
   parameter int SEARCH_TIMEOUT = 4096,
   parameter int SLIP_WAIT      = 16,
   parameter int LOCK_TIMEOUT   = 4096
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic [9:0] s_tmds_data,
   input  logic       s_tmds_valid,
   output logic       bitslip,
   output logic       aligned,
   output logic [7:0] m_video_data,
   output logic       m_video_de,
   output logic [1:0] m_video_ctrl,
   output logic       m_video_valid
);

   localparam int TOK_W  = $clog2(TOKEN_COUNT + 1);
   localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int GAP_W  = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------
   function automatic logic is_token(input logic [9:0] d);
      return (d == 10'h354) || (d == 10'h0AB) || (d == 10'h154) || (d == 10'h2AB);
   endfunction

   function automatic logic [1:0] token_ctrl(input logic [9:0] d);
      logic [1:0] c;
      case (d)
         10'h354: c = 2'b00;
         10'h0AB: c = 2'b01;
         10'h154: c = 2'b10;
         10'h2AB: c = 2'b11;
         default: c = 2'b00;
      endcase
      return c;
   endfunction

   // Inverse of the transmit-side transition minimisation. Bit 9 means the
   // payload was sent inverted. Bit 8 selects XOR or XNOR chaining.
   function automatic logic [7:0] tmds_decode(input logic [9:0] d);
      logic [7:0] x;
      logic [7:0] q;
      x    = d[9] ? ~d[7:0] : d[7:0];
      q[0] = x[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = d[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
      end
      return q;
   endfunction

   // Counters stop at their terminal value instead of wrapping.
   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
      return (v >= max) ? max : v + 1;
   endfunction

   // ---------------------------------------------------------------------------
   // Token detect on the incoming word (shared by the pipeline and the FSM)
   // ---------------------------------------------------------------------------
   logic       w_is_tok;
   logic [1:0] w_tok_ctrl;

   assign w_is_tok   = is_token(s_tmds_data);
   assign w_tok_ctrl = token_ctrl(s_tmds_data);

   // ---------------------------------------------------------------------------
   // Stage 1: register the raw word and the token-detect result
   // ---------------------------------------------------------------------------
   logic [9:0] r_word_p1;
   logic       r_tok_p1;
   logic [1:0] r_tokctrl_p1;
   logic       r_vld_p1;

   // ---------------------------------------------------------------------------
   // Stage 2: register the decoded outputs
   // ---------------------------------------------------------------------------
   logic [7:0] r_data_p2;
   logic       r_de_p2;
   logic [1:0] r_ctrl_p2;
   logic       r_vld_p2;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_word_p1    <= '0;
         r_tok_p1     <= 1'b0;
         r_tokctrl_p1 <= '0;
         r_vld_p1     <= 1'b0;
         r_data_p2    <= '0;
         r_de_p2      <= 1'b0;
         r_ctrl_p2    <= '0;
         r_vld_p2     <= 1'b0;
      end else begin
         r_vld_p1 <= s_tmds_valid;
         if (s_tmds_valid) begin
            r_word_p1    <= s_tmds_data;
            r_tok_p1     <= w_is_tok;
            r_tokctrl_p1 <= w_tok_ctrl;
         end
         r_vld_p2 <= r_vld_p1;
         // Outputs change only on valid words. The control code keeps its
         // last token value across data words.
         if (r_vld_p1) begin
            if (r_tok_p1) begin
               r_data_p2 <= '0;
               r_de_p2   <= 1'b0;
               r_ctrl_p2 <= r_tokctrl_p1;
            end else begin
               r_data_p2 <= tmds_decode(r_word_p1);
               r_de_p2   <= 1'b1;
            end
         end
      end
   end

   assign m_video_data  = r_data_p2;
   assign m_video_de    = r_de_p2;
   assign m_video_ctrl  = r_ctrl_p2;
   assign m_video_valid = r_vld_p2;

   // ---------------------------------------------------------------------------
   // Word-alignment FSM
   // ---------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic [TOK_W-1:0]    r_tok_run,  w_tok_nxt,  w_tok_inc;
   logic [TMO_W-1:0]    r_tmo,      w_tmo_nxt,  w_tmo_inc;
   logic [WAIT_W-1:0]   r_wait,     w_wait_nxt, w_wait_inc;
   logic [GAP_W-1:0]    r_gap,      w_gap_nxt,  w_gap_inc;
   logic                r_bitslip,  w_slip_nxt;

   assign w_tok_inc  = TOK_W'(sat_inc(32'(r_tok_run), TOKEN_COUNT));
   assign w_tmo_inc  = TMO_W'(sat_inc(32'(r_tmo), SEARCH_TIMEOUT));
   assign w_wait_inc = WAIT_W'(sat_inc(32'(r_wait), SLIP_WAIT));
   assign w_gap_inc  = GAP_W'(sat_inc(32'(r_gap), LOCK_TIMEOUT));

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state   <= ST_SEARCH;
         r_tok_run <= '0;
         r_tmo     <= '0;
         r_wait    <= '0;
         r_gap     <= '0;
         r_bitslip <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tok_run <= w_tok_nxt;
         r_tmo     <= w_tmo_nxt;
         r_wait    <= w_wait_nxt;
         r_gap     <= w_gap_nxt;
         r_bitslip <= w_slip_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tok_nxt   = r_tok_run;
      w_tmo_nxt   = r_tmo;
      w_wait_nxt  = r_wait;
      w_gap_nxt   = r_gap;
      w_slip_nxt  = 1'b0;

      // Invalid cycles freeze the state and every counter.
      if (s_tmds_valid) begin
         case (r_state)
            ST_SEARCH: begin
               w_tmo_nxt = w_tmo_inc;
               w_tok_nxt = w_is_tok ? w_tok_inc : '0;
               // Lock is checked first, so it wins when both limits are
               // reached on the same word.
               if (w_is_tok && (w_tok_inc == TOK_W'(TOKEN_COUNT))) begin
                  w_state_nxt = ST_LOCKED;
                  w_tok_nxt   = '0;
                  w_tmo_nxt   = '0;
                  w_gap_nxt   = '0;
               end else if (w_tmo_inc == TMO_W'(SEARCH_TIMEOUT)) begin
                  w_state_nxt = ST_SLIP_WAIT;
                  w_slip_nxt  = 1'b1;
                  w_tok_nxt   = '0;
                  w_tmo_nxt   = '0;
                  w_wait_nxt  = '0;
               end
            end
            ST_SLIP_WAIT: begin
               // The deserializer is still settling, so words seen here
               // never count toward lock.
               w_wait_nxt = w_wait_inc;
               if (w_wait_inc == WAIT_W'(SLIP_WAIT)) begin
                  w_state_nxt = ST_SEARCH;
                  w_wait_nxt  = '0;
                  w_tok_nxt   = '0;
                  w_tmo_nxt   = '0;
               end
            end
            ST_LOCKED: begin
               if (w_is_tok) begin
                  w_gap_nxt = '0;
               end else begin
                  w_gap_nxt = w_gap_inc;
                  if (w_gap_inc == GAP_W'(LOCK_TIMEOUT)) begin
                     w_state_nxt = ST_SEARCH;
                     w_gap_nxt   = '0;
                     w_tok_nxt   = '0;
                     w_tmo_nxt   = '0;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_SEARCH;
               w_tok_nxt   = '0;
               w_tmo_nxt   = '0;
               w_wait_nxt  = '0;
               w_gap_nxt   = '0;
            end
         endcase
      end
   end

   assign bitslip = r_bitslip;
   assign aligned = (r_state == ST_LOCKED);

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI/DVI TMDS transmit path: decodes one TMDS channel.
- Input is the 10-bit parallel word from an ISERDES-based deserializer, with bit 0 first on the wire.
- Outputs are 8-bit pixel data, data-enable and the 2-bit control code.
- Runs a word-alignment state machine that issues bitslip pulses to the deserializer until control tokens are seen consistently.
- One instance per channel; three instances plus a channel deskew block form the HDMI input path.

Parameters:
- TOKEN_COUNT, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096: valid words in SEARCH without lock before a bitslip is issued.
- SLIP_WAIT, 16: valid words ignored after a bitslip, to cover deserializer settling.
- LOCK_TIMEOUT, 4096: valid words in LOCKED without any control token before lock is dropped.

Ports:
- aclk  in  1  single clock, pixel-rate domain.
- aresetn  in  1  synchronous, active-low reset.
- s_tmds_data  in  10  deserialized TMDS word.
- s_tmds_valid  in  1  qualifies s_tmds_data.
- bitslip  out  1  one-cycle pulse to the deserializer to shift the word boundary by one bit.
- aligned  out  1  high while in LOCKED.
- m_video_data  out  8  decoded pixel byte.
- m_video_de  out  1  1 = data word, 0 = control token.
- m_video_ctrl  out  2  control code; held at its last value during data words.
- m_video_valid  out  1  qualifies the m_video_* outputs.

Behaviour:
- Reset: aresetn sampled low on an aclk edge clears all outputs to 0, clears all counters, sets FSM to SEARCH and flushes the pipeline. Reset mid-operation behaves identically.
- Control token decode (d = s_tmds_data):
  - 10'b1101010100 (0x354) -> ctrl 00
  - 10'b0010101011 (0x0AB) -> ctrl 01
  - 10'b0101010100 (0x154) -> ctrl 10
  - 10'b1010101011 (0x2AB) -> ctrl 11
  - Token words give m_video_de=0 and m_video_data=0.
- Data decode (any other word):
  - x = d[9] ? ~d[7:0] : d[7:0]
  - q[0] = x[0]
  - for i = 1..7: q[i] = d[8] ? x[i]^x[i-1] : ~(x[i]^x[i-1])
  - m_video_data = q, m_video_de = 1.
- Pipeline:
  - Fixed 2-cycle latency from input to output. Stage 1 registers the word plus the token-detect result; stage 2 registers the decoded outputs.
  - m_video_valid is s_tmds_valid delayed 2 cycles.
  - Decoding runs regardless of alignment; consumers gate on aligned.
- Counters advance only on cycles where s_tmds_valid=1. Invalid cycles freeze every counter and FSM state.
- FSM state SEARCH:
  - tok_run counts consecutive token words; any data word clears it.
  - tmo counts valid words in SEARCH.
  - tok_run reaching TOKEN_COUNT -> LOCKED, tmo cleared.
  - Otherwise tmo reaching SEARCH_TIMEOUT -> bitslip=1 for exactly one cycle -> SLIP_WAIT.
  - If both conditions occur on the same word, lock wins and no bitslip is issued.
- FSM state SLIP_WAIT:
  - Counts SLIP_WAIT valid words, then -> SEARCH with tok_run and tmo cleared.
  - Words seen in this state never count toward lock.
- FSM state LOCKED:
  - aligned=1 from the cycle after the transition, until the cycle after exit.
  - gap counts valid words since the last token and is cleared on every token.
  - gap reaching LOCK_TIMEOUT -> SEARCH, aligned=0, tok_run and tmo cleared.
  - No bitslip is issued while LOCKED.
- Counter widths are $clog2(max+1). Counters saturate, never wrap.
- bitslip is never high for two consecutive cycles.

Test Plan:
- Reset: drive random input with aresetn=0 for 5 cycles -> all outputs 0. First valid word after release produces m_video_valid=1 exactly 2 cycles later.
- Lock: 16 words of 0x354 then data -> aligned rises the cycle after the 8th token is accepted, with bitslip=0 throughout. Outputs show de=0, ctrl=00 at 2-cycle latency.
- Data decode vectors, after lock:
  - 0x100 -> data 0x00, de=1
  - 0x1FF -> 0x01
  - 0x2FF -> 0xFE
  - 0x0AB -> de=0, ctrl=01
  - ctrl holds its last value during the data words.
- Misalignment: bench deserializer model rotates the stream by 3 bits and undoes 1 bit per bitslip pulse. Feed 0x354 tokens continuously -> one-cycle bitslip pulses spaced SEARCH_TIMEOUT+SLIP_WAIT valid words apart. aligned rises TOKEN_COUNT words after the model becomes aligned, and no further bitslip follows.
- Lock loss: after lock, feed 4096 consecutive data words -> aligned falls after word 4096. Re-lock requires 8 tokens again. A single token at word 4095 keeps the lock.
- Gaps and reset: deassert s_tmds_valid on every other cycle during lock acquisition -> lock takes 8 valid tokens, not 8 cycles. Assert aresetn=0 mid-SLIP_WAIT -> returns to SEARCH with zero counters and no spurious bitslip.
